// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control decoder with an iterative MULT/DIV busy sequencer.
// Optional build macro UNSIGNED_MDU_EN enables MULTU/DIVU sequencing with mdu_signed = 0.
module alu_control_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       out_valid,
  output logic       mdu_start,
  output logic       mdu_div,
  output logic       mdu_signed,
  output logic       hilo_we,
  output logic       stall
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_DIV   = 6'h1A;
`ifdef UNSIGNED_MDU_EN
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1B;
`endif

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [3:0]       dec_ctrl;
  logic             is_mdu;
  logic [CNT_W-1:0] load_val;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    dec_ctrl = CTRL_ADD;
    if (alu_op == 2'b01) begin
      dec_ctrl = CTRL_SUB;
    end else if (alu_op[1]) begin
      case (funct)
        F_AND:   dec_ctrl = CTRL_AND;
        F_OR:    dec_ctrl = CTRL_OR;
        F_ADD:   dec_ctrl = CTRL_ADD;
        F_SUB:   dec_ctrl = CTRL_SUB;
        F_SLT:   dec_ctrl = CTRL_SLT;
        F_NOR:   dec_ctrl = CTRL_NOR;
        default: dec_ctrl = CTRL_ADD;
      endcase
    end
  end

  // MDU ops are only recognised for R-type; the same funct under LW/SW or branch decodes normally.
  always_comb begin
    is_mdu = 1'b0;
    if (alu_op[1]) begin
      case (funct)
        F_MULT, F_DIV:   is_mdu = 1'b1;
`ifdef UNSIGNED_MDU_EN
        F_MULTU, F_DIVU: is_mdu = 1'b1;
`endif
        default:         is_mdu = 1'b0;
      endcase
    end
  end

  assign load_val = funct[1] ? DIV_LOAD : MUL_LOAD;
  assign in_ready = (state == IDLE);
  assign stall    = ~in_ready;

`ifdef UNSIGNED_MDU_EN
  logic signed_q;
  assign mdu_signed = signed_q;
`else
  assign mdu_signed = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= CNT_ZERO;
      alu_ctrl  <= CTRL_ADD;
      out_valid <= 1'b0;
      mdu_start <= 1'b0;
      mdu_div   <= 1'b0;
      hilo_we   <= 1'b0;
`ifdef UNSIGNED_MDU_EN
      signed_q  <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      mdu_start <= 1'b0;
      hilo_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_mdu) begin
              state     <= BUSY;
              counter   <= load_val;
              mdu_start <= 1'b1;
              mdu_div   <= funct[1];
`ifdef UNSIGNED_MDU_EN
              signed_q  <= ~funct[0];
`endif
              // A single-cycle operation completes in the same cycle it starts.
              hilo_we   <= (load_val == CNT_ZERO);
              out_valid <= (load_val == CNT_ZERO);
            end else begin
              alu_ctrl  <= dec_ctrl;
              out_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (counter == CNT_ZERO) begin
            state <= IDLE;
          end else begin
            counter <= counter - CNT_ONE;
          end
          // Outputs are registered, so the final-cycle pulse is armed one edge early.
          if (counter == CNT_ONE) begin
            hilo_we   <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
